// File: rtl/data_ram_pipe.sv
// Word-addressed data RAM with byte-lane stores, a ReadLatency-stage response pipeline
// and a small in-order response FIFO; the outstanding-request count throttles acceptance.
module data_ram_pipe #(
    parameter int    AddressSize = 32,
    parameter int    WordSize    = 32,
    parameter int    Depth       = 4096,
    parameter int    ReadLatency = 1,
    parameter string InitFile    = ""
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [AddressSize-1:0] req_addr_i,
    input  logic [WordSize-1:0]    req_wdata_i,
    input  logic [WordSize/8-1:0]  req_be_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [WordSize-1:0]    rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   rsp_we_o
);
    localparam int Lanes     = WordSize / 8;
    localparam int OffBits   = $clog2(Lanes);
    localparam int IdxBits   = $clog2(Depth);
    localparam int FifoDepth = ReadLatency + 1;
    localparam int PtrBits   = $clog2(FifoDepth);
    localparam int CntBits   = $clog2(FifoDepth + 1);

    logic [WordSize-1:0]    mem [Depth];
    logic [IdxBits-1:0]     idx;
    logic                   addr_err;
    logic                   req_err;
    logic                   accept;
    logic                   pop;
    logic                   push;
    logic                   ready_en;
    logic [CntBits-1:0]     outstanding;

    logic [ReadLatency-1:0] pipe_valid;
    logic [ReadLatency-1:0] pipe_we;
    logic [ReadLatency-1:0] pipe_err;
    logic [WordSize-1:0]    pipe_data [ReadLatency];

    logic [WordSize-1:0]    fifo_data [FifoDepth];
    logic [FifoDepth-1:0]   fifo_we;
    logic [FifoDepth-1:0]   fifo_err;
    logic [PtrBits-1:0]     wr_ptr;
    logic [PtrBits-1:0]     rd_ptr;
    logic [CntBits-1:0]     fifo_count;

    function automatic logic [PtrBits-1:0] ptr_inc(input logic [PtrBits-1:0] p);
        return (p == PtrBits'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign idx      = req_addr_i[OffBits +: IdxBits];
    assign addr_err = (req_addr_i >> (OffBits + IdxBits)) != '0;
    assign req_err  = addr_err | (req_we_i & ~(|req_be_i));

    // ready_en keeps the port closed during reset and until the first edge after release.
    assign req_ready_o = ready_en & (outstanding < CntBits'(FifoDepth));
    assign accept      = req_valid_i & req_ready_o;
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign push        = pipe_valid[ReadLatency-1];

    assign rsp_valid_o = fifo_count != '0;
    assign rsp_rdata_o = fifo_data[rd_ptr];
    assign rsp_err_o   = fifo_err[rd_ptr];
    assign rsp_we_o    = fifo_we[rd_ptr];

    // Array is never reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (accept && req_we_i && !req_err) begin
            for (int b = 0; b < Lanes; b++) begin
                if (req_be_i[b]) mem[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en    <= 1'b0;
            outstanding <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept && !pop)      outstanding <= outstanding + 1'b1;
            else if (pop && !accept) outstanding <= outstanding - 1'b1;
        end
    end

    // Stage 0 captures the word at accept; a store done one edge earlier is already visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid <= '0;
            pipe_we    <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < ReadLatency; i++) pipe_data[i] <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_we[0]    <= req_we_i;
            pipe_err[0]   <= req_err;
            pipe_data[0]  <= (req_we_i || req_err) ? '0 : mem[idx];
            for (int i = 1; i < ReadLatency; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_we[i]    <= pipe_we[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    // Pop needs a non-empty FIFO, so a push into an empty FIFO is only seen next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_we    <= '0;
            fifo_err   <= '0;
            for (int i = 0; i < FifoDepth; i++) fifo_data[i] <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= pipe_data[ReadLatency-1];
                fifo_we[wr_ptr]   <= pipe_we[ReadLatency-1];
                fifo_err[wr_ptr]  <= pipe_err[ReadLatency-1];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

endmodule
